hazard_sequencer: RTL and testbench

- Pipeline hazard and stall sequencer for the 5-stage MIPS32 core.
- Drives the ID-stage control decoder's NOP input to insert bubbles on load-use hazards.
- Flushes IF/ID, ID/EX and EX/MEM when a branch resolves taken in MEM.
- Freezes the whole pipeline while the data memory handshake is pending; keeps saturating stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_sequencer_if.sv | 40 ++++
 rtl/sat_counter.sv | 23 ++
 rtl/hazard_sequencer.sv | 150 +++++++++++++++
 tb/tb_hazard_sequencer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, constants and hazard detect helper for the hazard sequencer
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         STALL_CNT_W = 4;

    // A load in EX whose destination feeds a source of the ID instruction; $zero never hazards.
    function automatic logic load_use_hit(
        input logic       mem_read_ex,
        input logic [4:0] rt_ex,
        input logic [4:0] rs_id,
        input logic [4:0] rt_id,
        input logic       uses_rt_id
    );
        return mem_read_ex && (rt_ex != REG_ZERO) &&
               ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));
    endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// rtl/hazard_sequencer_if.sv - pipeline-side hazard inputs and control outputs of the sequencer
interface hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs_ID;
    logic [4:0]       Rt_ID;
    logic             UsesRt_ID;
    logic             MemRead_EX;
    logic [4:0]       Rt_EX;
    logic             Branch_Taken_MEM;
    logic             DMem_Req_MEM;
    logic             DMem_Ready;
    logic             PC_Write;
    logic             IFID_Write;
    logic             ID_Control_NOP;
    logic             IFID_Flush;
    logic             IDEX_Flush;
    logic             EXMEM_Flush;
    logic             Pipeline_Freeze;
    logic             Mem_Error;
    logic [CNT_W-1:0] Stall_Count;
    logic [CNT_W-1:0] Flush_Count;

    modport slave (
        input  Rs_ID, Rt_ID, UsesRt_ID, MemRead_EX, Rt_EX,
        input  Branch_Taken_MEM, DMem_Req_MEM, DMem_Ready,
        output PC_Write, IFID_Write, ID_Control_NOP,
        output IFID_Flush, IDEX_Flush, EXMEM_Flush,
        output Pipeline_Freeze, Mem_Error, Stall_Count, Flush_Count
    );

    modport master (
        output Rs_ID, Rt_ID, UsesRt_ID, MemRead_EX, Rt_EX,
        output Branch_Taken_MEM, DMem_Req_MEM, DMem_Ready,
        input  PC_Write, IFID_Write, ID_Control_NOP,
        input  IFID_Flush, IDEX_Flush, EXMEM_Flush,
        input  Pipeline_Freeze, Mem_Error, Stall_Count, Flush_Count
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - load-use bubbles, taken-branch flushes and memory freeze for the 5-stage core
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255,
    parameter int CNT_W             = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_sequencer_if.slave hz
);

    localparam int FRZ_W = 16;

    state_t                 r_state;
    state_t                 w_state_next;
    state_t                 w_eff_state;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic [STALL_CNT_W-1:0] w_stall_cnt_next;
    logic [FRZ_W-1:0]       r_frz_cnt;
    logic [FRZ_W-1:0]       w_frz_cnt_next;
    logic                   r_mem_error;
    logic                   w_mem_error_set;
    logic                   w_load_use;
    logic                   w_mem_wait;
    logic                   w_stall_inc;
    logic                   w_flush_inc;
    logic                   w_pc_write;
    logic                   w_ifid_write;
    logic                   w_nop;
    logic                   w_flush;
    logic                   w_freeze;
    logic [CNT_W-1:0]       w_stall_count;
    logic [CNT_W-1:0]       w_flush_count;

    assign w_load_use = load_use_hit(hz.MemRead_EX, hz.Rt_EX, hz.Rs_ID, hz.Rt_ID, hz.UsesRt_ID);
    assign w_mem_wait = hz.DMem_Req_MEM & ~hz.DMem_Ready;

    // The release cycle out of WAIT already behaves as the state being returned to,
    // so a held bubble or a pending hazard is acted on without losing a cycle.
    always_comb begin
        w_eff_state = r_state;
        if (r_state == WAIT) begin
            w_eff_state = (r_stall_cnt != '0) ? STALL : RUN;
        end
    end

    always_comb begin
        w_state_next     = w_eff_state;
        w_stall_cnt_next = r_stall_cnt;
        w_pc_write       = 1'b1;
        w_ifid_write     = 1'b1;
        w_nop            = 1'b0;
        w_flush          = 1'b0;
        w_freeze         = 1'b0;
        w_stall_inc      = 1'b0;
        w_flush_inc      = 1'b0;

        if (w_mem_wait) begin
            w_freeze     = 1'b1;
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_state_next = WAIT;
        end else if (hz.Branch_Taken_MEM) begin
            w_flush          = 1'b1;
            w_flush_inc      = 1'b1;
            w_stall_cnt_next = '0;
            w_state_next     = RUN;
        end else if (w_eff_state == STALL) begin
            w_pc_write       = 1'b0;
            w_ifid_write     = 1'b0;
            w_nop            = 1'b1;
            w_stall_inc      = 1'b1;
            w_stall_cnt_next = r_stall_cnt - 1'b1;
            w_state_next     = (r_stall_cnt <= 1) ? RUN : STALL;
        end else if (w_load_use) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_nop        = 1'b1;
            w_stall_inc  = 1'b1;
            w_state_next = RUN;
            if (LOAD_STALL_CYCLES > 1) begin
                w_stall_cnt_next = STALL_CNT_W'(LOAD_STALL_CYCLES - 1);
                w_state_next     = STALL;
            end
        end

        if (!rst_n) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_nop        = 1'b1;
            w_flush      = 1'b0;
            w_freeze     = 1'b0;
            w_stall_inc  = 1'b0;
            w_flush_inc  = 1'b0;
        end
    end

    always_comb begin
        w_frz_cnt_next = '0;
        if (w_mem_wait) begin
            w_frz_cnt_next = (r_frz_cnt == {FRZ_W{1'b1}}) ? r_frz_cnt : r_frz_cnt + 1'b1;
        end
    end

    assign w_mem_error_set = w_mem_wait && (w_frz_cnt_next >= FRZ_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_frz_cnt   <= '0;
            r_mem_error <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_stall_cnt <= w_stall_cnt_next;
            r_frz_cnt   <= w_frz_cnt_next;
            if (w_mem_error_set) begin
                r_mem_error <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .count (w_stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush_inc),
        .count (w_flush_count)
    );

    assign hz.PC_Write        = w_pc_write;
    assign hz.IFID_Write      = w_ifid_write;
    assign hz.ID_Control_NOP  = w_nop;
    assign hz.IFID_Flush      = w_flush;
    assign hz.IDEX_Flush      = w_flush;
    assign hz.EXMEM_Flush     = w_flush;
    assign hz.Pipeline_Freeze = w_freeze;
    assign hz.Mem_Error       = r_mem_error;
    assign hz.Stall_Count     = w_stall_count;
    assign hz.Flush_Count     = w_flush_count;

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - scoreboard bench for hazard_sequencer with default and short-timeout instances
module tb_hazard_sequencer;

    // ctl = {PC_Write, IFID_Write, ID_Control_NOP, IFID_Flush, IDEX_Flush, EXMEM_Flush, Pipeline_Freeze, Mem_Error}
    localparam logic [7:0] C_RST = 8'b0010_0000;
    localparam logic [7:0] C_NRM = 8'b1100_0000;
    localparam logic [7:0] C_STL = 8'b0010_0000;
    localparam logic [7:0] C_FLS = 8'b1101_1100;
    localparam logic [7:0] C_FRZ = 8'b0000_0010;

    typedef struct {
        int         cyc;
        bit         sel;
        string      name;
        logic [7:0] ctl;
        int         sc;
        int         fc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   errors;
    int   checks;
    exp_t q[$];

    hazard_sequencer_if #(.CNT_W(16)) ifa ();
    hazard_sequencer_if #(.CNT_W(2))  ifb ();

    hazard_sequencer #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(255), .CNT_W(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ifa)
    );

    hazard_sequencer #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ifb)
    );

    logic [7:0] ctl_a;
    logic [7:0] ctl_b;
    assign ctl_a = {ifa.PC_Write, ifa.IFID_Write, ifa.ID_Control_NOP, ifa.IFID_Flush,
                    ifa.IDEX_Flush, ifa.EXMEM_Flush, ifa.Pipeline_Freeze, ifa.Mem_Error};
    assign ctl_b = {ifb.PC_Write, ifb.IFID_Write, ifb.ID_Control_NOP, ifb.IFID_Flush,
                    ifb.IDEX_Flush, ifb.EXMEM_Flush, ifb.Pipeline_Freeze, ifb.Mem_Error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t       m_e;
    logic [7:0] m_ctl;
    int         m_sc;
    int         m_fc;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e   = q.pop_front();
            m_ctl = m_e.sel ? ctl_b : ctl_a;
            m_sc  = m_e.sel ? int'(ifb.Stall_Count) : int'(ifa.Stall_Count);
            m_fc  = m_e.sel ? int'(ifb.Flush_Count) : int'(ifa.Flush_Count);
            checks++;
            if (m_e.cyc != cyc || m_ctl !== m_e.ctl) begin
                errors++;
                $display("FAIL %s.ctl actual=%b required=%b (cycle %0d/%0d)",
                         m_e.name, m_ctl, m_e.ctl, cyc, m_e.cyc);
            end
            checks++;
            if (m_sc != m_e.sc) begin
                errors++;
                $display("FAIL %s.stall_count actual=%0d required=%0d", m_e.name, m_sc, m_e.sc);
            end
            checks++;
            if (m_fc != m_e.fc) begin
                errors++;
                $display("FAIL %s.flush_count actual=%0d required=%0d", m_e.name, m_fc, m_e.fc);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic exp(input bit sel, input string name, input logic [7:0] ctl, input int sc, input int fc);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.name = name;
        e.ctl  = ctl;
        e.sc   = sc;
        e.fc   = fc;
        q.push_back(e);
    endtask

    task automatic drv(input bit sel, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic mr, input logic [4:0] rtex, input logic br,
                       input logic req, input logic rdy);
        if (sel) begin
            ifb.Rs_ID = rs; ifb.Rt_ID = rt; ifb.UsesRt_ID = ur; ifb.MemRead_EX = mr;
            ifb.Rt_EX = rtex; ifb.Branch_Taken_MEM = br; ifb.DMem_Req_MEM = req; ifb.DMem_Ready = rdy;
        end else begin
            ifa.Rs_ID = rs; ifa.Rt_ID = rt; ifa.UsesRt_ID = ur; ifa.MemRead_EX = mr;
            ifa.Rt_EX = rtex; ifa.Branch_Taken_MEM = br; ifa.DMem_Req_MEM = req; ifa.DMem_Ready = rdy;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);

        nxt(); exp(0, "reset_a", C_RST, 0, 0); exp(1, "reset_b", C_RST, 0, 0);

        // default instance: single-bubble load-use, filters, branch and freeze priority
        nxt(); rst_n = 1'b1; drv(0, 8, 0, 0, 1, 8, 0, 0, 0); exp(0, "lu_rs", C_STL, 0, 0);
        nxt(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0); exp(0, "lu_after", C_NRM, 1, 0);
        nxt(); drv(0, 0, 0, 0, 1, 0, 0, 0, 0); exp(0, "rt_zero", C_NRM, 1, 0);
        nxt(); drv(0, 3, 8, 0, 1, 8, 0, 0, 0); exp(0, "rt_unused", C_NRM, 1, 0);
        nxt(); drv(0, 3, 8, 1, 1, 8, 0, 0, 0); exp(0, "lu_rt", C_STL, 1, 0);
        nxt(); drv(0, 8, 0, 0, 1, 8, 1, 0, 0); exp(0, "br_over_lu", C_FLS, 2, 0);
        nxt(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0); exp(0, "br_after", C_NRM, 2, 1);
        nxt(); drv(0, 0, 0, 0, 0, 0, 0, 1, 0); exp(0, "frz_a", C_FRZ, 2, 1);
        nxt(); drv(0, 8, 0, 0, 1, 8, 0, 1, 1); exp(0, "lu_after_frz", C_STL, 2, 1);
        nxt(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0); exp(0, "norm_a", C_NRM, 3, 1);
        nxt(); drv(0, 0, 0, 0, 0, 0, 1, 1, 0); exp(0, "frz_over_br", C_FRZ, 3, 1);
        nxt(); drv(0, 0, 0, 0, 0, 0, 1, 0, 0); exp(0, "br_after_frz", C_FLS, 3, 1);
        nxt(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0); exp(0, "norm_a2", C_NRM, 3, 2);

        // three-bubble instance with 2-bit counters and a 4-cycle timeout
        nxt(); drv(1, 8, 0, 0, 1, 8, 0, 0, 0); exp(1, "b_lu", C_STL, 0, 0);
        nxt(); drv(1, 0, 0, 0, 0, 0, 0, 0, 0); exp(1, "b_stall1", C_STL, 1, 0);
        nxt(); exp(1, "b_stall2", C_STL, 2, 0);
        nxt(); exp(1, "b_run", C_NRM, 3, 0);
        nxt(); drv(1, 8, 0, 0, 1, 8, 0, 0, 0); exp(1, "b_lu_sat", C_STL, 3, 0);
        for (int i = 0; i < 5; i++) begin
            nxt(); drv(1, 0, 0, 0, 0, 0, 0, 1, 0);
            exp(1, $sformatf("b_frz%0d", i), (i == 4) ? (C_FRZ | 8'd1) : C_FRZ, 3, 0);
        end
        nxt(); drv(1, 0, 0, 0, 0, 0, 0, 0, 0); exp(1, "b_bub1", C_STL | 8'd1, 3, 0);
        nxt(); exp(1, "b_bub2", C_STL | 8'd1, 3, 0);
        nxt(); exp(1, "b_run_err", C_NRM | 8'd1, 3, 0);
        nxt(); drv(1, 8, 0, 0, 1, 8, 0, 0, 0); exp(1, "b_lu2", C_STL | 8'd1, 3, 0);
        nxt(); drv(1, 0, 0, 0, 0, 0, 0, 0, 0); rst_n = 1'b0;
        exp(1, "b_rst", C_RST, 0, 0); exp(0, "a_rst", C_RST, 0, 0);
        nxt(); rst_n = 1'b1; exp(1, "b_post_rst", C_NRM, 0, 0);
        nxt(); exp(1, "b_run_rst", C_NRM, 0, 0);

        nxt();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expectations actual=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
